// File: rtl/phy_rx_lane_sync_if.sv
// Byte-lane bundle between the two deserializers, the lane-sync block and the
// downstream byte consumers.
interface phy_rx_lane_sync_if;
  logic [7:0] data_in_0;
  logic       valid_in_0;
  logic [7:0] data_in_1;
  logic       valid_in_1;
  logic [7:0] data_out_0;
  logic       valid_out_0;
  logic [7:0] data_out_1;
  logic       valid_out_1;
  logic       lock_0;
  logic       lock_1;
  logic       all_locked;

  modport master (
    output data_in_0, valid_in_0, data_in_1, valid_in_1,
    input  data_out_0, valid_out_0, data_out_1, valid_out_1,
    input  lock_0, lock_1, all_locked
  );

  modport slave (
    input  data_in_0, valid_in_0, data_in_1, valid_in_1,
    output data_out_0, valid_out_0, data_out_1, valid_out_1,
    output lock_0, lock_1, all_locked
  );
endinterface

// File: rtl/phy_rx_lane_sync.sv
// Two independent per-lane word-lock FSMs: hunt for a run of COMMA bytes,
// forward non-comma data while locked, drop lock on idle or comma starvation.
module phy_rx_lane_sync #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned MAX_GAP  = 64
) (
  input  logic              clk_f,
  input  logic              reset,
  phy_rx_lane_sync_if.slave lanes
);
  localparam int NUM_LANES = 2;
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int GW = $clog2(MAX_GAP + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [CW-1:0] COMMA_LAST = CW'(LOCK_CNT - 1);
  localparam logic [GW-1:0] GAP_LIMIT  = GW'(MAX_GAP);
  localparam logic [LW-1:0] LOSS_LAST  = LW'(LOSS_CNT - 1);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  logic [7:0] data_in   [NUM_LANES];
  logic       valid_in  [NUM_LANES];
  logic [7:0] data_out  [NUM_LANES];
  logic       valid_out [NUM_LANES];
  logic       lock      [NUM_LANES];
  logic       lock_next [NUM_LANES];
  logic       all_locked_reg;

  assign data_in[0]  = lanes.data_in_0;
  assign valid_in[0] = lanes.valid_in_0;
  assign data_in[1]  = lanes.data_in_1;
  assign valid_in[1] = lanes.valid_in_1;

  assign lanes.data_out_0  = data_out[0];
  assign lanes.valid_out_0 = valid_out[0];
  assign lanes.data_out_1  = data_out[1];
  assign lanes.valid_out_1 = valid_out[1];
  assign lanes.lock_0      = lock[0];
  assign lanes.lock_1      = lock[1];
  assign lanes.all_locked  = all_locked_reg;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    state_t          state_reg, state_next;
    logic [CW-1:0]   comma_reg, comma_next;
    logic [GW-1:0]   gap_reg,   gap_next;
    logic [LW-1:0]   loss_reg,  loss_next;
    logic [7:0]      data_reg,  data_next;
    logic            valid_reg, valid_next;
    logic            is_comma;

    assign is_comma = valid_in[gi] && (data_in[gi] == COMMA);

    always_ff @(posedge clk_f or posedge reset) begin
      if (reset) begin
        state_reg <= HUNT;
        comma_reg <= '0;
        gap_reg   <= '0;
        loss_reg  <= '0;
        data_reg  <= '0;
        valid_reg <= 1'b0;
      end else begin
        state_reg <= state_next;
        comma_reg <= comma_next;
        gap_reg   <= gap_next;
        loss_reg  <= loss_next;
        data_reg  <= data_next;
        valid_reg <= valid_next;
      end
    end

    always_comb begin
      state_next = state_reg;
      comma_next = comma_reg;
      gap_next   = gap_reg;
      loss_next  = loss_reg;
      data_next  = data_reg;
      valid_next = 1'b0;
      if (state_reg == HUNT) begin
        if (!is_comma) begin
          comma_next = '0;
        end else if (comma_reg == COMMA_LAST) begin
          state_next = LOCK;
          comma_next = '0;
          gap_next   = '0;
          loss_next  = '0;
        end else begin
          comma_next = comma_reg + 1'b1;
        end
      end else begin
        // Any exit back to HUNT clears every counter so the triggering byte
        // never contributes to the next comma run.
        if (!valid_in[gi]) begin
          if (loss_reg == LOSS_LAST) begin
            state_next = HUNT;
            comma_next = '0;
            gap_next   = '0;
            loss_next  = '0;
          end else begin
            loss_next = loss_reg + 1'b1;
          end
        end else if (is_comma) begin
          gap_next  = '0;
          loss_next = '0;
        end else if (gap_reg == GAP_LIMIT) begin
          state_next = HUNT;
          comma_next = '0;
          gap_next   = '0;
          loss_next  = '0;
        end else begin
          gap_next   = gap_reg + 1'b1;
          loss_next  = '0;
          data_next  = data_in[gi];
          valid_next = 1'b1;
        end
      end
    end

    assign lock_next[gi] = (state_next == LOCK);
    assign lock[gi]      = (state_reg == LOCK);
    assign data_out[gi]  = data_reg;
    assign valid_out[gi] = valid_reg;
  end

  // Derived from the next-state locks so it changes on the same edge as lock_n.
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      all_locked_reg <= 1'b0;
    end else begin
      all_locked_reg <= lock_next[0] && lock_next[1];
    end
  end
endmodule

// File: tb/tb_phy_rx_lane_sync.sv
// Randomized and directed bench for phy_rx_lane_sync against a rule-level
// per-lane reference model (comma run, bytes since comma, idle streak).
module tb_phy_rx_lane_sync;
  localparam logic [7:0] COMMA = 8'hBC;

  logic clk_f = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  phy_rx_lane_sync_if lanes ();

  phy_rx_lane_sync dut (
    .clk_f (clk_f),
    .reset (reset),
    .lanes (lanes.slave)
  );

  always #5 clk_f = ~clk_f;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference model state per lane
  bit         m_locked [2];
  int         m_run    [2];
  int         m_gap    [2];
  int         m_loss   [2];
  logic [7:0] m_dout   [2];
  bit         m_vout   [2];

  task automatic model_drop(int l);
    m_locked[l] = 1'b0;
    m_vout[l]   = 1'b0;
    m_run[l]    = 0;
    m_gap[l]    = 0;
    m_loss[l]   = 0;
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      model_drop(l);
      m_dout[l] = 8'h00;
    end
  endtask

  task automatic model_edge(int l, logic [7:0] d, bit v);
    bit comma = v && (d == COMMA);
    if (!m_locked[l]) begin
      m_vout[l] = 1'b0;
      m_run[l]  = comma ? m_run[l] + 1 : 0;
      if (m_run[l] == 4) begin
        m_locked[l] = 1'b1;
        m_run[l]    = 0;
        m_gap[l]    = 0;
        m_loss[l]   = 0;
      end
    end else if (!v) begin
      m_vout[l] = 1'b0;
      m_loss[l]++;
      if (m_loss[l] == 3) model_drop(l);
    end else if (comma) begin
      m_gap[l]  = 0;
      m_loss[l] = 0;
      m_vout[l] = 1'b0;
    end else if (m_gap[l] == 64) begin
      model_drop(l);
    end else begin
      m_gap[l]++;
      m_loss[l] = 0;
      m_dout[l] = d;
      m_vout[l] = 1'b1;
    end
  endtask

  function automatic logic [20:0] observed();
    return {lanes.all_locked, lanes.lock_1, lanes.lock_0, lanes.valid_out_1,
            lanes.valid_out_0, lanes.data_out_1, lanes.data_out_0};
  endfunction

  function automatic logic [20:0] expected();
    return {m_locked[0] & m_locked[1], m_locked[1], m_locked[0], m_vout[1],
            m_vout[0], m_dout[1], m_dout[0]};
  endfunction

  function automatic logic [7:0] rand_data();
    logic [7:0] b;
    do b = 8'($urandom); while (b == COMMA);
    return b;
  endfunction

  // One byte per lane: drive on the falling edge, model the rising edge,
  // leave the caller 1 ns after the rising edge to sample.
  task automatic step(logic [7:0] d0, bit v0, logic [7:0] d1, bit v1);
    @(negedge clk_f);
    lanes.data_in_0  = d0;
    lanes.valid_in_0 = v0;
    lanes.data_in_1  = d1;
    lanes.valid_in_1 = v1;
    @(posedge clk_f);
    model_edge(0, d0, v0);
    model_edge(1, d1, v1);
    #1;
    cycle++;
    $display("cyc %0d in0=%h/%b in1=%h/%b -> out0=%h/%b out1=%h/%b lock=%b%b all=%b",
             cycle, d0, v0, d1, v1, lanes.data_out_0, lanes.valid_out_0,
             lanes.data_out_1, lanes.valid_out_1, lanes.lock_0, lanes.lock_1,
             lanes.all_locked);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    lanes.data_in_0  = 8'h00;
    lanes.valid_in_0 = 1'b0;
    lanes.data_in_1  = 8'h00;
    lanes.valid_in_1 = 1'b0;
    repeat (2) @(posedge clk_f);
    #1;
    model_reset();
    checks++;
    if (observed() !== 21'h0) begin
      errors++;
      $display("FAIL reset_state: got %h required %h", observed(), 21'h0);
    end
    @(negedge clk_f);
    reset = 1'b0;
  endtask

  task automatic test_lock_and_forward();
    for (int i = 0; i < 4; i++) begin
      step(COMMA, 1'b1, 8'h00, 1'b0);
      checks++;
      if (lanes.lock_0 !== (i == 3)) begin
        errors++;
        $display("FAIL lock_after_comma%0d: got %b required %b", i + 1, lanes.lock_0, i == 3);
      end
    end
    step(8'hA5, 1'b1, 8'h00, 1'b0);
    checks++;
    if ({lanes.valid_out_0, lanes.data_out_0} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL forward_a5: got %b/%h required 1/a5", lanes.valid_out_0, lanes.data_out_0);
    end
    step(COMMA, 1'b1, 8'h00, 1'b0);
    checks++;
    if (observed() !== expected()) begin
      errors++;
      $display("FAIL comma_not_forwarded: got %h required %h", observed(), expected());
    end
  endtask

  task automatic test_loss_of_valid();
    for (int i = 0; i < 3; i++) begin
      step(COMMA, 1'b0, 8'h00, 1'b0);
      checks++;
      if ({lanes.lock_0, lanes.valid_out_0} !== {i < 2, 1'b0}) begin
        errors++;
        $display("FAIL loss_cycle%0d: got lock/valid %b%b required %b0",
                 i + 1, lanes.lock_0, lanes.valid_out_0, i < 2);
      end
    end
    for (int i = 0; i < 4; i++) step(COMMA, 1'b1, 8'h00, 1'b0);
    step(8'h00, 1'b0, 8'h00, 1'b0);
    step(8'h00, 1'b0, 8'h00, 1'b0);
    step(8'h3C, 1'b1, 8'h00, 1'b0);
    checks++;
    if ({lanes.lock_0, lanes.valid_out_0, lanes.data_out_0} !== {2'b11, 8'h3C}) begin
      errors++;
      $display("FAIL two_idle_keeps_lock: got %b%b/%h required 11/3c",
               lanes.lock_0, lanes.valid_out_0, lanes.data_out_0);
    end
  endtask

  task automatic test_broken_run();
    logic [7:0] seq [8];
    seq = '{COMMA, COMMA, COMMA, 8'h00, COMMA, COMMA, COMMA, COMMA};
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(seq[i], 1'b1, 8'h00, 1'b0);
      checks++;
      if (lanes.lock_0 !== (i == 7)) begin
        errors++;
        $display("FAIL broken_run_byte%0d: got lock %b required %b", i + 1, lanes.lock_0, i == 7);
      end
    end
  endtask

  task automatic test_comma_gap();
    logic [7:0] b;
    logic [7:0] last;
    step(COMMA, 1'b1, 8'h00, 1'b0);
    for (int i = 1; i <= 64; i++) begin
      b = rand_data();
      step(b, 1'b1, 8'h00, 1'b0);
      checks++;
      if ({lanes.lock_0, lanes.valid_out_0, lanes.data_out_0} !== {2'b11, b}) begin
        errors++;
        $display("FAIL gap_byte%0d: got %b%b/%h required 11/%h",
                 i, lanes.lock_0, lanes.valid_out_0, lanes.data_out_0, b);
      end
    end
    last = b;
    step(rand_data(), 1'b1, 8'h00, 1'b0);
    checks++;
    if ({lanes.lock_0, lanes.valid_out_0, lanes.data_out_0} !== {2'b00, last}) begin
      errors++;
      $display("FAIL gap_byte65_dropped: got %b%b/%h required 00/%h",
               lanes.lock_0, lanes.valid_out_0, lanes.data_out_0, last);
    end
    for (int i = 0; i < 4; i++) step(COMMA, 1'b1, 8'h00, 1'b0);
    step(COMMA, 1'b1, 8'h00, 1'b0);
    for (int i = 1; i <= 63; i++) step(rand_data(), 1'b1, 8'h00, 1'b0);
    step(COMMA, 1'b1, 8'h00, 1'b0);
    for (int i = 1; i <= 64; i++) begin
      step(rand_data(), 1'b1, 8'h00, 1'b0);
      checks++;
      if (observed() !== expected() || lanes.lock_0 !== 1'b1) begin
        errors++;
        $display("FAIL gap_refreshed_byte%0d: got %h required %h", i, observed(), expected());
      end
    end
  endtask

  task automatic test_independent_lanes();
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(rand_data(), 1'b1, COMMA, 1'b1);
    checks++;
    if ({lanes.lock_1, lanes.lock_0, lanes.all_locked} !== 3'b100) begin
      errors++;
      $display("FAIL lane1_only: got lock1/lock0/all %b%b%b required 100",
               lanes.lock_1, lanes.lock_0, lanes.all_locked);
    end
    for (int i = 0; i < 4; i++) begin
      step(COMMA, 1'b1, COMMA, 1'b1);
      checks++;
      if (lanes.all_locked !== (i == 3)) begin
        errors++;
        $display("FAIL all_locked_comma%0d: got %b required %b", i + 1, lanes.all_locked, i == 3);
      end
    end
  endtask

  task automatic test_reset_midstream();
    step(8'h11, 1'b1, 8'h22, 1'b1);
    checks++;
    if (observed() !== expected()) begin
      errors++;
      $display("FAIL pre_reset_forward: got %h required %h", observed(), expected());
    end
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (observed() !== 21'h0) begin
      errors++;
      $display("FAIL async_reset: got %h required %h", observed(), 21'h0);
    end
    @(negedge clk_f);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(COMMA, 1'b1, COMMA, 1'b1);
      checks++;
      if ({lanes.lock_0, lanes.lock_1, lanes.all_locked} !== {3{i == 3}}) begin
        errors++;
        $display("FAIL relock_comma%0d: got %b%b%b required %b",
                 i + 1, lanes.lock_0, lanes.lock_1, lanes.all_locked, i == 3);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d [2];
    bit         v [2];
    for (int n = 0; n < 400; n++) begin
      for (int l = 0; l < 2; l++) begin
        v[l] = ($urandom_range(99) < 85);
        d[l] = ($urandom_range(99) < 40) ? COMMA : 8'($urandom);
      end
      step(d[0], v[0], d[1], v[1]);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL random_step%0d: got %h required %h", n, observed(), expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_and_forward();
    test_loss_of_valid();
    test_broken_run();
    test_comma_gap();
    test_independent_lanes();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
